pc_ifid_ctrl: RTL and testbench

PC_IFID_CTRL -- requirements
Module: pc_ifid_ctrl

---
 rtl/pc_ifid_ctrl_pkg.sv | 38 +++
 rtl/pc_ifid_ctrl_if.sv | 47 ++++
 rtl/pc_ifid_ctrl_pipe_reg.sv | 35 +++
 rtl/pc_ifid_ctrl.sv | 144 ++++++++++++++
 tb/tb_pc_ifid_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_ifid_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pc_ifid_ctrl_pkg
// Shared definitions for the fetch-stage PC / IF-ID controller:
//   - pcSrcE     : ID-stage next-PC select encodings
//   - ifIdT      : packed layout of the IF/ID pipeline register
//   - vectors    : default reset PC, illegal-op and external-address vectors
//   - NOP        : default bubble instruction
//   - pcIncrement: sequential PC step (wraps modulo 2^32)
// -----------------------------------------------------------------------------
package pc_ifid_ctrl_pkg;

    typedef enum logic [2:0] {
        PCSRC_SEQ   = 3'b000,
        PCSRC_JUMP  = 3'b001,
        PCSRC_JR    = 3'b010,
        PCSRC_ILLOP = 3'b011,
        PCSRC_XADR  = 3'b100
    } pcSrcE;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pcPlus4;
        logic        valid;
    } ifIdT;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h8000_0000;
    localparam logic [31:0] ILLOP_VECTOR      = 32'h8000_0004;
    localparam logic [31:0] XADR_VECTOR       = 32'h8000_0008;
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;
    localparam logic [15:0] COUNT_MAX         = 16'hFFFF;

    // Plain 32-bit add: the carry out of bit 31 is simply dropped so the
    // address space wraps from FFFFFFFC back to 00000000.
    function automatic logic [31:0] pcIncrement(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/pc_ifid_ctrl_if.sv
// -----------------------------------------------------------------------------
// pc_ifid_ctrl_if
// Bundles the control/target inputs and the PC / IF-ID outputs of the
// fetch controller.
//   master : the surrounding pipeline (hazard unit, ID, EX, instruction memory)
//   slave  : pc_ifid_ctrl itself
// Optional feature macro: PC_IFID_STALL_CNT_EN adds StallCount / FlushCount.
// -----------------------------------------------------------------------------
interface pc_ifid_ctrl_if;

    logic        Stall;
    logic [2:0]  PCSrc;
    logic        BranchTaken_EX;
    logic [31:0] BranchTarget;
    logic [31:0] JumpTarget;
    logic [31:0] JrTarget;
    logic [31:0] Instruction;
    logic [31:0] PC;
    logic [31:0] IF_ID_Instruction;
    logic [31:0] IF_ID_PC_plus_4;
    logic        IF_ID_Valid;
`ifdef PC_IFID_STALL_CNT_EN
    logic [15:0] StallCount;
    logic [15:0] FlushCount;
`endif

`ifdef PC_IFID_STALL_CNT_EN
    modport master (
        output Stall, PCSrc, BranchTaken_EX, BranchTarget, JumpTarget, JrTarget, Instruction,
        input  PC, IF_ID_Instruction, IF_ID_PC_plus_4, IF_ID_Valid, StallCount, FlushCount
    );
    modport slave (
        input  Stall, PCSrc, BranchTaken_EX, BranchTarget, JumpTarget, JrTarget, Instruction,
        output PC, IF_ID_Instruction, IF_ID_PC_plus_4, IF_ID_Valid, StallCount, FlushCount
    );
`else
    modport master (
        output Stall, PCSrc, BranchTaken_EX, BranchTarget, JumpTarget, JrTarget, Instruction,
        input  PC, IF_ID_Instruction, IF_ID_PC_plus_4, IF_ID_Valid
    );
    modport slave (
        input  Stall, PCSrc, BranchTaken_EX, BranchTarget, JumpTarget, JrTarget, Instruction,
        output PC, IF_ID_Instruction, IF_ID_PC_plus_4, IF_ID_Valid
    );
`endif

endinterface

// File: rtl/pc_ifid_ctrl_pipe_reg.sv
// -----------------------------------------------------------------------------
// pipe_reg
// Generic pipeline register with asynchronous active-high reset, load enable
// and a synchronous flush that loads a caller-supplied value.
//   clk, reset : clock and async reset (reset loads RESET_VALUE)
//   enable     : load d when high (the owner drives it with hold negated)
//   flush      : load flushValue; overrides enable
//   flushValue : value loaded on flush
//   d / q      : data in / registered data out
// -----------------------------------------------------------------------------
module pipe_reg #(
    parameter int                WIDTH       = 32,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             flush,
    input  logic [WIDTH-1:0] flushValue,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Flush wins over enable so a squash still lands while the stage is held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RESET_VALUE;
        end else if (flush) begin
            q <= flushValue;
        end else if (enable) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pc_ifid_ctrl.sv
// -----------------------------------------------------------------------------
// pc_ifid_ctrl
// Program counter and IF/ID register control for a 5-stage pipeline.
// Each cycle, in priority order: EX branch redirect (flush), hazard stall
// (hold everything), ID-stage redirect via PCSrc (flush one delay slot),
// otherwise sequential fetch.
// Ports:
//   clk   : sole clock, rising edge
//   reset : asynchronous, active-high
//   bus   : pc_ifid_ctrl_if.slave (targets, controls, fetched instruction in;
//           PC and IF/ID contents out)
// Parameters: RESET_PC, NOP_INSTR.
// Optional feature macro: PC_IFID_STALL_CNT_EN adds saturating StallCount and
// FlushCount outputs on the interface.
// -----------------------------------------------------------------------------
module pc_ifid_ctrl
    import pc_ifid_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic          clk,
    input  logic          reset,
    pc_ifid_ctrl_if.slave bus
);

    localparam ifIdT IFID_RESET = '{instruction: NOP_INSTR, pcPlus4: RESET_PC, valid: 1'b0};

    logic [31:0] pcReg;
    logic [31:0] pcPlus4;
    logic [31:0] idTarget;
    logic        idRedirect;
    logic        holdNow;
    logic        flushNow;
    logic [31:0] nextPc;
    pcSrcE       pcSel;
    ifIdT        ifIdD;
    ifIdT        ifIdFlush;
    ifIdT        ifIdQ;

    assign pcPlus4 = pcIncrement(pcReg);
    assign pcSel   = pcSrcE'(bus.PCSrc);

    // Decode the ID-stage select into a target; unused encodings fall back to
    // sequential fetch and do not count as a redirect.
    always_comb begin
        idTarget   = pcPlus4;
        idRedirect = 1'b0;
        case (pcSel)
            PCSRC_JUMP: begin
                idTarget   = bus.JumpTarget;
                idRedirect = 1'b1;
            end
            PCSRC_JR: begin
                idTarget   = bus.JrTarget;
                idRedirect = 1'b1;
            end
            PCSRC_ILLOP: begin
                idTarget   = ILLOP_VECTOR;
                idRedirect = 1'b1;
            end
            PCSRC_XADR: begin
                idTarget   = XADR_VECTOR;
                idRedirect = 1'b1;
            end
            default: begin
                idTarget   = pcPlus4;
                idRedirect = 1'b0;
            end
        endcase
    end

    // A taken branch overrides the stall; PCSrc only matters when the stage
    // is free to move.
    assign holdNow  = ~bus.BranchTaken_EX & bus.Stall;
    assign flushNow = bus.BranchTaken_EX | (~bus.Stall & idRedirect);

    // Next PC follows the same priority chain as the hold/flush decisions.
    always_comb begin
        nextPc = pcPlus4;
        if (bus.BranchTaken_EX) begin
            nextPc = bus.BranchTarget;
        end else if (bus.Stall) begin
            nextPc = pcReg;
        end else if (idRedirect) begin
            nextPc = idTarget;
        end
    end

    // The PC register itself; reset takes effect immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcReg <= RESET_PC;
        end else begin
            pcReg <= nextPc;
        end
    end

    assign ifIdD     = '{instruction: bus.Instruction, pcPlus4: pcPlus4, valid: 1'b1};
    assign ifIdFlush = '{instruction: NOP_INSTR, pcPlus4: pcPlus4, valid: 1'b0};

    pipe_reg #(
        .WIDTH       ($bits(ifIdT)),
        .RESET_VALUE (IFID_RESET)
    ) ifIdReg (
        .clk        (clk),
        .reset      (reset),
        .enable     (~holdNow),
        .flush      (flushNow),
        .flushValue (ifIdFlush),
        .d          (ifIdD),
        .q          (ifIdQ)
    );

    assign bus.PC                = pcReg;
    assign bus.IF_ID_Instruction = ifIdQ.instruction;
    assign bus.IF_ID_PC_plus_4   = ifIdQ.pcPlus4;
    assign bus.IF_ID_Valid       = ifIdQ.valid;

`ifdef PC_IFID_STALL_CNT_EN
    logic [15:0] stallCount;
    logic [15:0] flushCount;

    // Saturating event counters: one tick per held cycle and one per squash
    // cycle (branch or ID redirect).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stallCount <= '0;
            flushCount <= '0;
        end else begin
            if (holdNow && stallCount != COUNT_MAX) begin
                stallCount <= stallCount + 16'd1;
            end
            if (flushNow && flushCount != COUNT_MAX) begin
                flushCount <= flushCount + 16'd1;
            end
        end
    end

    assign bus.StallCount = stallCount;
    assign bus.FlushCount = flushCount;
`endif

endmodule

// File: tb/tb_pc_ifid_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_ifid_ctrl
// Directed testbench for pc_ifid_ctrl. Optional feature macro
// PC_IFID_STALL_CNT_EN enables the counter scenario.
// -----------------------------------------------------------------------------
module tb_pc_ifid_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    pc_ifid_ctrl_if bus ();

    pc_ifid_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic setIdle();
        bus.Stall          = 1'b0;
        bus.PCSrc          = 3'b000;
        bus.BranchTaken_EX = 1'b0;
        bus.BranchTarget   = 32'h0;
        bus.JumpTarget     = 32'h0;
        bus.JrTarget       = 32'h0;
        bus.Instruction    = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        setIdle();
        #2;
        checks++; if (bus.PC !== 32'h80000000) begin failures++; $display("[TB] FAIL reset_pc got %h want 80000000", bus.PC); end
        checks++; if (bus.IF_ID_Instruction !== 32'h0) begin failures++; $display("[TB] FAIL reset_instr got %h want 00000000", bus.IF_ID_Instruction); end
        checks++; if (bus.IF_ID_PC_plus_4 !== 32'h80000000) begin failures++; $display("[TB] FAIL reset_pc4 got %h want 80000000", bus.IF_ID_PC_plus_4); end
        checks++; if (bus.IF_ID_Valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got %b want 0", bus.IF_ID_Valid); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] instrs [3];
        bus.Instruction = 32'h20080001;
        stepEdge();
        checks++; if (bus.PC !== 32'h80000004) begin failures++; $display("[TB] FAIL seq_pc got %h want 80000004", bus.PC); end
        checks++; if (bus.IF_ID_Instruction !== 32'h20080001) begin failures++; $display("[TB] FAIL seq_instr got %h want 20080001", bus.IF_ID_Instruction); end
        checks++; if (bus.IF_ID_PC_plus_4 !== 32'h80000004) begin failures++; $display("[TB] FAIL seq_pc4 got %h want 80000004", bus.IF_ID_PC_plus_4); end
        checks++; if (bus.IF_ID_Valid !== 1'b1) begin failures++; $display("[TB] FAIL seq_valid got %b want 1", bus.IF_ID_Valid); end
        instrs[0] = 32'h11111111;
        instrs[1] = 32'h22222222;
        instrs[2] = 32'h33333333;
        for (int i = 0; i < 3; i++) begin
            bus.Instruction = instrs[i];
            stepEdge();
        end
        checks++; if (bus.PC !== 32'h80000010) begin failures++; $display("[TB] FAIL seq4_pc got %h want 80000010", bus.PC); end
        checks++; if (bus.IF_ID_Instruction !== 32'h33333333) begin failures++; $display("[TB] FAIL seq4_instr got %h want 33333333", bus.IF_ID_Instruction); end
        checks++; if (bus.IF_ID_PC_plus_4 !== 32'h80000010) begin failures++; $display("[TB] FAIL seq4_pc4 got %h want 80000010", bus.IF_ID_PC_plus_4); end
    endtask

    // PC sits at 80000010 with IF/ID holding 33333333 / 80000010.
    task automatic test_stall();
        bus.Stall       = 1'b1;
        bus.PCSrc       = 3'b001;
        bus.JumpTarget  = 32'h12345678;
        bus.Instruction = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            stepEdge();
            checks++; if (bus.PC !== 32'h80000010) begin failures++; $display("[TB] FAIL stall_pc[%0d] got %h want 80000010", i, bus.PC); end
            checks++; if (bus.IF_ID_Instruction !== 32'h33333333) begin failures++; $display("[TB] FAIL stall_instr[%0d] got %h want 33333333", i, bus.IF_ID_Instruction); end
            checks++; if (bus.IF_ID_Valid !== 1'b1) begin failures++; $display("[TB] FAIL stall_valid[%0d] got %b want 1", i, bus.IF_ID_Valid); end
        end
        bus.Stall       = 1'b0;
        bus.PCSrc       = 3'b000;
        bus.Instruction = 32'h44444444;
        stepEdge();
        checks++; if (bus.PC !== 32'h80000014) begin failures++; $display("[TB] FAIL unstall_pc got %h want 80000014", bus.PC); end
        checks++; if (bus.IF_ID_Instruction !== 32'h44444444) begin failures++; $display("[TB] FAIL unstall_instr got %h want 44444444", bus.IF_ID_Instruction); end
        checks++; if (bus.IF_ID_PC_plus_4 !== 32'h80000014) begin failures++; $display("[TB] FAIL unstall_pc4 got %h want 80000014", bus.IF_ID_PC_plus_4); end
    endtask

    // A stall released with PCSrc still asserted must take the redirect.
    task automatic test_stall_release_redirect();
        bus.Stall       = 1'b1;
        bus.PCSrc       = 3'b001;
        bus.JumpTarget  = 32'h00001000;
        bus.Instruction = 32'h99999999;
        stepEdge();
        checks++; if (bus.PC !== 32'h80000014) begin failures++; $display("[TB] FAIL held_jump_pc got %h want 80000014", bus.PC); end
        bus.Stall = 1'b0;
        stepEdge();
        checks++; if (bus.PC !== 32'h00001000) begin failures++; $display("[TB] FAIL released_jump_pc got %h want 00001000", bus.PC); end
        checks++; if (bus.IF_ID_Valid !== 1'b0) begin failures++; $display("[TB] FAIL released_jump_valid got %b want 0", bus.IF_ID_Valid); end
        bus.PCSrc = 3'b000;
    endtask

    task automatic test_jr();
        bus.PCSrc       = 3'b010;
        bus.JrTarget    = 32'h00400020;
        bus.Instruction = 32'h55555555;
        stepEdge();
        checks++; if (bus.PC !== 32'h00400020) begin failures++; $display("[TB] FAIL jr_pc got %h want 00400020", bus.PC); end
        checks++; if (bus.IF_ID_Instruction !== 32'h0) begin failures++; $display("[TB] FAIL jr_instr got %h want 00000000", bus.IF_ID_Instruction); end
        checks++; if (bus.IF_ID_Valid !== 1'b0) begin failures++; $display("[TB] FAIL jr_valid got %b want 0", bus.IF_ID_Valid); end
        bus.PCSrc       = 3'b000;
        bus.Instruction = 32'h66666666;
        stepEdge();
        checks++; if (bus.PC !== 32'h00400024) begin failures++; $display("[TB] FAIL postjr_pc got %h want 00400024", bus.PC); end
        checks++; if (bus.IF_ID_Instruction !== 32'h66666666) begin failures++; $display("[TB] FAIL postjr_instr got %h want 66666666", bus.IF_ID_Instruction); end
        checks++; if (bus.IF_ID_PC_plus_4 !== 32'h00400024) begin failures++; $display("[TB] FAIL postjr_pc4 got %h want 00400024", bus.IF_ID_PC_plus_4); end
        checks++; if (bus.IF_ID_Valid !== 1'b1) begin failures++; $display("[TB] FAIL postjr_valid got %b want 1", bus.IF_ID_Valid); end
    endtask

    task automatic test_vectors();
        bus.PCSrc = 3'b011;
        stepEdge();
        checks++; if (bus.PC !== 32'h80000004) begin failures++; $display("[TB] FAIL illop_pc got %h want 80000004", bus.PC); end
        checks++; if (bus.IF_ID_Valid !== 1'b0) begin failures++; $display("[TB] FAIL illop_valid got %b want 0", bus.IF_ID_Valid); end
        bus.PCSrc = 3'b100;
        stepEdge();
        checks++; if (bus.PC !== 32'h80000008) begin failures++; $display("[TB] FAIL xadr_pc got %h want 80000008", bus.PC); end
        bus.PCSrc       = 3'b111;
        bus.Instruction = 32'hABCD0123;
        stepEdge();
        checks++; if (bus.PC !== 32'h8000000C) begin failures++; $display("[TB] FAIL pcsrc111_pc got %h want 8000000c", bus.PC); end
        checks++; if (bus.IF_ID_Instruction !== 32'hABCD0123) begin failures++; $display("[TB] FAIL pcsrc111_instr got %h want abcd0123", bus.IF_ID_Instruction); end
        checks++; if (bus.IF_ID_Valid !== 1'b1) begin failures++; $display("[TB] FAIL pcsrc111_valid got %b want 1", bus.IF_ID_Valid); end
        bus.PCSrc      = 3'b001;
        bus.JumpTarget = 32'hFFFFFFFC;
        stepEdge();
        checks++; if (bus.PC !== 32'hFFFFFFFC) begin failures++; $display("[TB] FAIL jump_pc got %h want fffffffc", bus.PC); end
        bus.PCSrc = 3'b000;
    endtask

    task automatic test_wrap();
        bus.Instruction = 32'h77777777;
        stepEdge();
        checks++; if (bus.PC !== 32'h00000000) begin failures++; $display("[TB] FAIL wrap_pc got %h want 00000000", bus.PC); end
        checks++; if (bus.IF_ID_PC_plus_4 !== 32'h00000000) begin failures++; $display("[TB] FAIL wrap_pc4 got %h want 00000000", bus.IF_ID_PC_plus_4); end
        checks++; if (bus.IF_ID_Instruction !== 32'h77777777) begin failures++; $display("[TB] FAIL wrap_instr got %h want 77777777", bus.IF_ID_Instruction); end
    endtask

    task automatic test_branch_priority();
        bus.BranchTaken_EX = 1'b1;
        bus.BranchTarget   = 32'h80000100;
        bus.Stall          = 1'b1;
        bus.PCSrc          = 3'b001;
        bus.JumpTarget     = 32'h00002000;
        bus.Instruction    = 32'h88888888;
        stepEdge();
        checks++; if (bus.PC !== 32'h80000100) begin failures++; $display("[TB] FAIL branch_pc got %h want 80000100", bus.PC); end
        checks++; if (bus.IF_ID_Instruction !== 32'h0) begin failures++; $display("[TB] FAIL branch_instr got %h want 00000000", bus.IF_ID_Instruction); end
        checks++; if (bus.IF_ID_Valid !== 1'b0) begin failures++; $display("[TB] FAIL branch_valid got %b want 0", bus.IF_ID_Valid); end
        setIdle();
    endtask

    // Reset arriving in the middle of a stall takes effect without a clock.
    task automatic test_reset_mid_stall();
        bus.Stall = 1'b1;
        stepEdge();
        #2;
        reset = 1'b1;
        #1;
        checks++; if (bus.PC !== 32'h80000000) begin failures++; $display("[TB] FAIL midreset_pc got %h want 80000000", bus.PC); end
        checks++; if (bus.IF_ID_Valid !== 1'b0) begin failures++; $display("[TB] FAIL midreset_valid got %b want 0", bus.IF_ID_Valid); end
        @(negedge clk);
        reset     = 1'b0;
        bus.Stall = 1'b0;
        bus.Instruction = 32'h20080001;
        stepEdge();
        checks++; if (bus.PC !== 32'h80000004) begin failures++; $display("[TB] FAIL postreset_pc got %h want 80000004", bus.PC); end
    endtask

`ifdef PC_IFID_STALL_CNT_EN
    task automatic test_counters();
        reset = 1'b1;
        setIdle();
        #1;
        checks++; if (bus.StallCount !== 16'd0) begin failures++; $display("[TB] FAIL cnt_reset_stall got %0d want 0", bus.StallCount); end
        checks++; if (bus.FlushCount !== 16'd0) begin failures++; $display("[TB] FAIL cnt_reset_flush got %0d want 0", bus.FlushCount); end
        @(negedge clk);
        reset     = 1'b0;
        bus.Stall = 1'b1;
        stepEdge();
        stepEdge();
        bus.Stall    = 1'b0;
        bus.PCSrc    = 3'b010;
        bus.JrTarget = 32'h00400020;
        stepEdge();
        checks++; if (bus.StallCount !== 16'd2) begin failures++; $display("[TB] FAIL cnt_stall got %0d want 2", bus.StallCount); end
        checks++; if (bus.FlushCount !== 16'd1) begin failures++; $display("[TB] FAIL cnt_flush got %0d want 1", bus.FlushCount); end
        bus.PCSrc = 3'b000;
        bus.Stall = 1'b1;
        stepEdge();
        #2;
        reset = 1'b1;
        #1;
        checks++; if (bus.StallCount !== 16'd0) begin failures++; $display("[TB] FAIL cnt_midreset_stall got %0d want 0", bus.StallCount); end
        checks++; if (bus.FlushCount !== 16'd0) begin failures++; $display("[TB] FAIL cnt_midreset_flush got %0d want 0", bus.FlushCount); end
        checks++; if (bus.PC !== 32'h80000000) begin failures++; $display("[TB] FAIL cnt_midreset_pc got %h want 80000000", bus.PC); end
        @(negedge clk);
        reset = 1'b0;
        setIdle();
    endtask
`endif

    // Scenarios run in order; each leaves the state the next one expects.
    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_sequential();
        test_stall();
        test_stall_release_redirect();
        test_jr();
        test_vectors();
        test_wrap();
        test_branch_priority();
        test_reset_mid_stall();
`ifdef PC_IFID_STALL_CNT_EN
        test_counters();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
